// File: rtl/multdiv_pkg.sv
// Shared constants and operation encoding for the iterative multiply/divide unit.
package multdiv_pkg;

    localparam int WIDTH = 32;          // operand and result width
    localparam int LAST  = WIDTH + 1;   // count value at which the result is presented
    localparam int CNT_W = 6;           // enough bits to hold 0..LAST

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_e;

endpackage

// File: rtl/multdiv_step.sv
// One iteration of the shared datapath: a radix-2 Booth add/sub plus arithmetic
// shift for multiply, or a restoring subtract-and-shift for divide.
//
// Multiply keeps the product as {hi, lo, bit}. hi is one bit wider than the
// operand so that subtracting a most-negative multiplicand cannot wrap.
// Divide keeps the partial remainder in hi and the dividend/quotient in lo.
module multdiv_step
    import multdiv_pkg::*;
#(
    parameter int WIDTH = multdiv_pkg::WIDTH
) (
    input  op_e              op_i,
    input  logic [WIDTH:0]   hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic             bit_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH:0]   hi_o,
    output logic [WIDTH-1:0] lo_o,
    output logic             bit_o
);

    logic [WIDTH:0] m_ext;
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    assign m_ext = {m_i[WIDTH-1], m_i};

    // Next-state of the working registers for one multiply or divide step.
    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        sum    = hi_i;
        rem_sh = '0;
        trial  = '0;
        hi_o   = hi_i;
        lo_o   = lo_i;
        bit_o  = bit_i;
        if (op_i == OP_MULT) begin
            case ({lo_i[0], bit_i})
                2'b01:   sum = hi_i + m_ext;
                2'b10:   sum = hi_i - m_ext;
                default: sum = hi_i;
            endcase
            hi_o  = {sum[WIDTH], sum[WIDTH:1]};
            lo_o  = {sum[0], lo_i[WIDTH-1:1]};
            bit_o = lo_i[0];
        end else begin
            rem_sh = {hi_i[WIDTH-1:0], lo_i[WIDTH-1]};
            trial  = rem_sh - {1'b0, m_i};
            if (!trial[WIDTH]) begin
                hi_o = trial;
                lo_o = {lo_i[WIDTH-2:0], 1'b1};
            end else begin
                hi_o = rem_sh;
                lo_o = {lo_i[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/multdiv_iter.sv
// Iterative signed multiply/divide unit for the execute stage. A start loads
// count=1, steps run at counts 1..32, and the result is presented with a
// one-cycle ready strobe while count==33. A new start always aborts and restarts.
module multdiv_iter #(
    parameter int WIDTH = multdiv_pkg::WIDTH,
    parameter int LAST  = multdiv_pkg::LAST
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    import multdiv_pkg::op_e;
    import multdiv_pkg::OP_MULT;
    import multdiv_pkg::OP_DIV;
    import multdiv_pkg::CNT_W;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(LAST);
    localparam logic [CNT_W-1:0] CNT_STEP_END = CNT_W'(LAST - 1);

    logic [CNT_W-1:0] count_q, count_d;
    op_e              op_q;
    logic [WIDTH:0]   hi_q;
    logic [WIDTH-1:0] lo_q, m_q;
    logic             bit_q, neg_q;
    logic [WIDTH-1:0] result_q;
    logic             exc_q;

    logic             start, step_en;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   step_hi;
    logic [WIDTH-1:0] step_lo;
    logic             step_bit;
    logic [WIDTH:0]   prod_top;
    logic [WIDTH-1:0] fin_result;
    logic             fin_exc;

    assign start   = ctrl_MULT | ctrl_DIV;
    assign step_en = (count_q != '0) && (count_q != CNT_LAST);
    assign a_mag   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
    assign b_mag   = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

    multdiv_step #(.WIDTH(WIDTH)) u_step (
        .op_i  (op_q),
        .hi_i  (hi_q),
        .lo_i  (lo_q),
        .bit_i (bit_q),
        .m_i   (m_q),
        .hi_o  (step_hi),
        .lo_o  (step_lo),
        .bit_o (step_bit)
    );

    // Sequence counter: start wins over everything, 33 wraps back to idle.
    always_comb begin
        count_d = count_q + 1'b1;
        if (start) begin
            count_d = CNT_W'(1);
        end else if (count_q == '0 || count_q == CNT_LAST) begin
            count_d = '0;
        end
    end

    // Count register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Operand/accumulator registers: load on start, advance one step per busy cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_MULT;
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            bit_q <= 1'b0;
            neg_q <= 1'b0;
        end else if (start) begin
            hi_q  <= '0;
            bit_q <= 1'b0;
            if (ctrl_MULT) begin
                op_q  <= OP_MULT;
                lo_q  <= data_operandA;
                m_q   <= data_operandB;
                neg_q <= 1'b0;
            end else begin
                op_q  <= OP_DIV;
                lo_q  <= a_mag;
                m_q   <= b_mag;
                neg_q <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            end
        end else if (step_en) begin
            hi_q  <= step_hi;
            lo_q  <= step_lo;
            bit_q <= step_bit;
        end
    end

    // Final fix-up from the last step: product overflow, quotient sign, special cases.
    always_comb begin
        prod_top   = {step_hi[WIDTH-1:0], step_lo[WIDTH-1]};
        fin_result = step_lo;
        fin_exc    = 1'b0;
        if (op_q == OP_MULT) begin
            fin_exc = !((&prod_top) || (~|prod_top));
        end else if (m_q == '0) begin
            fin_result = '0;
            fin_exc    = 1'b1;
        end else begin
            fin_result = neg_q ? (~step_lo + 1'b1) : step_lo;
            // A positive quotient with the top bit set only arises from -2^31 / -1.
            fin_exc    = !neg_q && step_lo[WIDTH-1];
        end
    end

    // Result registers: written only on the edge entering count 33, held otherwise.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_q <= '0;
            exc_q    <= 1'b0;
        end else if (!start && count_q == CNT_STEP_END) begin
            result_q <= fin_result;
            exc_q    <= fin_exc;
        end
    end

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = (count_q == CNT_LAST);
    assign busy           = (count_q != '0);

endmodule
